// File: rtl/pico_io_hub.sv
// pico_io_hub: kcpsm6 port-bus hub with decoded output registers,
// synchronised input channels, a registered read mux and a change-detect
// interrupt controller driving the interrupt/interrupt_ack handshake.
module pico_io_hub #(
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned N_IN     = 4,
  parameter logic [7:0]  OUT_BASE = 8'h00,
  parameter logic [7:0]  IN_BASE  = 8'h00,
  parameter logic [7:0]  IRQ_BASE = 8'h20,
  parameter logic [7:0]  OUT_INIT = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            port_id,
  input  logic [7:0]            out_port,
  input  logic                  write_strobe,
  input  logic                  k_write_strobe,
  input  logic                  read_strobe,
  output logic [7:0]            in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  input  logic [8*N_IN-1:0]     ext_in,
  output logic [8*N_OUT-1:0]    ext_out,
  output logic [N_OUT-1:0]      out_wr
);

  // Addresses are compared in 9 bits so BASE+index never wraps onto a low port.
  localparam logic [8:0] IRQ_STAT_ADDR = {1'b0, IRQ_BASE};
  localparam logic [8:0] IRQ_MASK_ADDR = {1'b0, IRQ_BASE} + 9'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [8:0]                port_x;
  logic [N_OUT-1:0]          out_hit;
  logic                      irq_stat_wr;
  logic                      irq_mask_wr;
  logic [N_IN-1:0]           chg;
  logic [7:0]                rd_data;

  logic [N_OUT-1:0][7:0]     out_q;
  logic [N_OUT-1:0]          out_wr_q;
  logic [N_IN-1:0][7:0]      sync1_q;
  logic [N_IN-1:0][7:0]      sync2_q;
  logic [N_IN-1:0][7:0]      prev_q;
  logic [N_IN-1:0]           pending_q;
  logic [N_IN-1:0]           pending_d;
  logic [N_IN-1:0]           mask_q;
  logic [7:0]                in_port_q;
  state_t                    state_q;
  logic                      irq_q;

  // read_strobe carries no side effects in this hub.
  logic unused_read;
  assign unused_read = read_strobe;

  assign port_x      = {1'b0, port_id};
  assign irq_stat_wr = write_strobe && (port_x == IRQ_STAT_ADDR);
  assign irq_mask_wr = write_strobe && (port_x == IRQ_MASK_ADDR);

  // Output register decode: OUTPUT uses the full address, OUTPUTK the low nibble.
  always_comb begin
    out_hit = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (write_strobe && (port_x == (9'(OUT_BASE) + 9'(i)))) begin
        out_hit[i] = 1'b1;
      end
      if (k_write_strobe && (port_id[3:0] == 4'(i))) begin
        out_hit[i] = 1'b1;
      end
    end
  end

  // Output registers and their one-cycle update pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q    <= {N_OUT{OUT_INIT}};
      out_wr_q <= '0;
    end else begin
      out_wr_q <= out_hit;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (out_hit[i]) begin
          out_q[i] <= out_port;
        end
      end
    end
  end

  // Two-flop synchroniser plus previous-sample register per input channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ext_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Per-channel change detect on the synchronised samples.
  always_comb begin
    chg = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      chg[i] = |(sync2_q[i] ^ prev_q[i]);
    end
  end

  // Write-1-to-clear pending; a same-cycle new change overrides the clear.
  always_comb begin
    pending_d = pending_q;
    if (irq_stat_wr) begin
      pending_d = pending_q & ~out_port[N_IN-1:0];
    end
    pending_d = pending_d | chg;
  end

  // Pending and mask registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (irq_mask_wr) begin
        mask_q <= out_port[N_IN-1:0];
      end
    end
  end

  // Read mux; input channels override IRQ registers on address overlap.
  always_comb begin
    rd_data = 8'h00;
    if (port_x == IRQ_STAT_ADDR) begin
      rd_data = 8'(pending_q);
    end else if (port_x == IRQ_MASK_ADDR) begin
      rd_data = 8'(mask_q);
    end
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (port_x == (9'(IN_BASE) + 9'(i))) begin
        rd_data = sync2_q[i];
      end
    end
  end

  // Registered read data, updated every cycle from port_id.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_port_q <= 8'h00;
    end else begin
      in_port_q <= rd_data;
    end
  end

  // Interrupt handshake FSM with registered request output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((pending_q & mask_q) != '0) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (interrupt_ack) begin
            state_q <= ST_SERVICE;
            irq_q   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_stat_wr) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ext_out   = out_q;
  assign out_wr    = out_wr_q;
  assign in_port   = in_port_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_pico_io_hub.sv
// Self-checking bench for pico_io_hub: directed scenarios followed by
// randomized bus/input traffic against a behavioural reference model.
module tb_pico_io_hub;

  localparam int unsigned N_OUT    = 4;
  localparam int unsigned N_IN     = 4;
  localparam logic [7:0]  OUT_BASE = 8'h00;
  localparam logic [7:0]  IN_BASE  = 8'h00;
  localparam logic [7:0]  IRQ_BASE = 8'h20;
  localparam logic [7:0]  OUT_INIT = 8'hA5;
  localparam logic [7:0]  IN_MASK  = 8'h0F;

  logic                 clk;
  logic                 reset_n;
  logic [7:0]           port_id;
  logic [7:0]           out_port;
  logic                 write_strobe;
  logic                 k_write_strobe;
  logic                 read_strobe;
  logic [7:0]           in_port;
  logic                 interrupt;
  logic                 interrupt_ack;
  logic [8*N_IN-1:0]    ext_in;
  logic [8*N_OUT-1:0]   ext_out;
  logic [N_OUT-1:0]     out_wr;

  int checks;
  int failures;

  // Reference model state (values after the most recent clock edge).
  logic [7:0]           m_out [N_OUT];
  logic [N_OUT-1:0]     m_wr;
  logic [7:0]           m_in_port;
  logic [8*N_IN-1:0]    hist [3];  // input seen 1, 2 and 3 edges ago
  logic [7:0]           m_pend;
  logic [7:0]           m_mask;
  bit                   m_irq;     // request currently raised
  bit                   m_svc;     // acknowledged, awaiting status write

  pico_io_hub #(
    .N_OUT(N_OUT), .N_IN(N_IN), .OUT_BASE(OUT_BASE), .IN_BASE(IN_BASE),
    .IRQ_BASE(IRQ_BASE), .OUT_INIT(OUT_INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
    .read_strobe(read_strobe), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .ext_in(ext_in), .ext_out(ext_out),
    .out_wr(out_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*N_OUT-1:0] exp_ext_out();
    logic [8*N_OUT-1:0] v;
    for (int i = 0; i < int'(N_OUT); i++) v[8*i +: 8] = m_out[i];
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int         idx;
    logic [7:0] rd;
    logic [7:0] chg;
    logic [7:0] clr;
    bit         stat_wr;
    if (reset_n !== 1'b1) begin
      for (int i = 0; i < int'(N_OUT); i++) m_out[i] = OUT_INIT;
      m_wr = '0; m_in_port = 8'h00; m_pend = 8'h00; m_mask = 8'h00;
      m_irq = 1'b0; m_svc = 1'b0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
      return;
    end
    stat_wr = write_strobe && (port_id == IRQ_BASE);
    // read data from the state before the edge
    idx = int'(port_id) - int'(IN_BASE);
    if (idx >= 0 && idx < int'(N_IN)) rd = hist[1][8*idx +: 8];
    else if (port_id == IRQ_BASE) rd = m_pend;
    else if (int'(port_id) == int'(IRQ_BASE) + 1) rd = m_mask;
    else rd = 8'h00;
    m_in_port = rd;
    // interrupt handshake
    if (m_irq) begin
      if (interrupt_ack) begin m_irq = 1'b0; m_svc = 1'b1; end
    end else if (m_svc) begin
      if (stat_wr) m_svc = 1'b0;
    end else if ((m_pend & m_mask) != 8'h00) begin
      m_irq = 1'b1;
    end
    // change detect and W1C, with set winning
    chg = 8'h00;
    for (int c = 0; c < int'(N_IN); c++)
      if (hist[1][8*c +: 8] != hist[2][8*c +: 8]) chg[c] = 1'b1;
    clr = stat_wr ? out_port : 8'h00;
    m_pend = ((m_pend & ~clr) | chg) & IN_MASK;
    if (write_strobe && int'(port_id) == int'(IRQ_BASE) + 1) m_mask = out_port & IN_MASK;
    // output registers
    m_wr = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      if ((write_strobe && (int'(port_id) - int'(OUT_BASE) == i)) ||
          (k_write_strobe && (int'(port_id[3:0]) == i))) begin
        m_out[i] = out_port;
        m_wr[i]  = 1'b1;
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = ext_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ext_out", 32'(ext_out), 32'(exp_ext_out()));
    chk("out_wr", 32'(out_wr), 32'(m_wr));
    chk("in_port", 32'(in_port), 32'(m_in_port));
    chk("interrupt", 32'(interrupt), 32'(m_irq));
  endtask

  initial begin
    logic [7:0] addrs [12];
    int         sel;
    int         ch;
    checks = 0;
    failures = 0;
    addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
              8'h20, 8'h21, 8'hF0, 8'hF3, 8'hF7, 8'hFE};
    reset_n = 1'b0; port_id = IRQ_BASE; out_port = 8'h00;
    write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; ext_in = '0;

    // reset
    step(); step();
    chk("rst_ext_out", 32'(ext_out), 32'hA5A5A5A5);
    chk("rst_irq", 32'(interrupt), 32'h0);
    reset_n = 1'b1;
    step();
    chk("rst_rd_status", 32'(in_port), 32'h00);

    // OUTPUT write to register 2
    port_id = 8'h02; out_port = 8'h3C; write_strobe = 1'b1;
    step();
    chk("wr2_data", 32'(ext_out[23:16]), 32'h3C);
    chk("wr2_pulse", 32'(out_wr), 32'h4);
    write_strobe = 1'b0;
    step();
    chk("wr2_pulse_end", 32'(out_wr), 32'h0);

    // OUTPUTK writes: in range and out of range
    port_id = 8'hF1; out_port = 8'h77; k_write_strobe = 1'b1;
    step();
    chk("k_wr1", 32'(ext_out[15:8]), 32'h77);
    port_id = 8'hF9; out_port = 8'h11;
    step();
    chk("k_ignored", 32'(ext_out), 32'hA53C77A5);
    chk("k_ignored_pulse", 32'(out_wr), 32'h0);
    k_write_strobe = 1'b0;

    // input channel read and unmapped read
    ext_in[31:24] = 8'h5A; port_id = 8'h03;
    step(); step(); step(); step();
    chk("rd_ch3", 32'(in_port), 32'h5A);
    port_id = 8'hFE;
    step();
    chk("rd_unmapped", 32'(in_port), 32'h00);

    // clear pending, mask = 1
    write_strobe = 1'b1; port_id = IRQ_BASE; out_port = 8'hFF;
    step();
    port_id = IRQ_BASE + 8'd1; out_port = 8'h01;
    step();
    write_strobe = 1'b0;

    // ch0 change -> interrupt four edges later
    ext_in[7:0] = 8'h01; port_id = IRQ_BASE;
    step(); step(); step();
    chk("irq_not_yet", 32'(interrupt), 32'h0);
    step();
    chk("irq_raise", 32'(interrupt), 32'h1);
    step(); step();
    chk("irq_hold", 32'(interrupt), 32'h1);
    interrupt_ack = 1'b1;
    step();
    chk("irq_ack_drop", 32'(interrupt), 32'h0);
    interrupt_ack = 1'b0;
    step();
    chk("svc_low", 32'(interrupt), 32'h0);
    write_strobe = 1'b1; out_port = 8'h01;
    step();
    write_strobe = 1'b0;
    step();
    chk("svc_done_low", 32'(interrupt), 32'h0);
    chk("pend_cleared", 32'(in_port), 32'h00);

    // masked event, then unmask
    write_strobe = 1'b1; port_id = IRQ_BASE + 8'd1; out_port = 8'h00;
    step();
    write_strobe = 1'b0; ext_in[23:16] = 8'h10; port_id = IRQ_BASE;
    step(); step(); step(); step(); step();
    chk("pend_masked", 32'(in_port), 32'h04);
    chk("no_irq_masked", 32'(interrupt), 32'h0);
    write_strobe = 1'b1; port_id = IRQ_BASE + 8'd1; out_port = 8'h04;
    step();
    write_strobe = 1'b0;
    step();
    chk("irq_unmask", 32'(interrupt), 32'h1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0; write_strobe = 1'b1; port_id = IRQ_BASE; out_port = 8'h04;
    step();
    write_strobe = 1'b0;
    step();

    // W1C colliding with a new ch2 change: set wins
    ext_in[23:16] = 8'h30;
    step(); step();
    write_strobe = 1'b1; port_id = IRQ_BASE; out_port = 8'h04;
    step();
    write_strobe = 1'b0;
    step();
    chk("set_wins", 32'(in_port), 32'h04);
    chk("irq_rereq", 32'(interrupt), 32'h1);

    // reset while requesting
    reset_n = 1'b0;
    step();
    chk("rst_mid_irq", 32'(interrupt), 32'h0);
    reset_n = 1'b1; port_id = IRQ_BASE;
    step();
    chk("rst_mid_pend", 32'(in_port), 32'h00);
    port_id = IRQ_BASE + 8'd1;
    step();
    chk("rst_mid_mask", 32'(in_port), 32'h00);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 99));
      write_strobe   = (sel < 15);
      k_write_strobe = (sel >= 15 && sel < 22);
      read_strobe    = 1'($urandom);
      sel = int'($urandom_range(0, 12));
      if (sel == 12) port_id = 8'($urandom);
      else port_id = addrs[sel];
      out_port = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        ch = int'($urandom_range(0, N_IN - 1));
        ext_in[8*ch +: 8] = ext_in[8*ch +: 8] ^ 8'($urandom_range(1, 255));
      end
      if (interrupt) interrupt_ack = ($urandom_range(0, 9) < 3);
      else interrupt_ack = ($urandom_range(0, 49) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
